op_sequencer: RTL and testbench

OP_SEQUENCER -- requirements
Module: op_sequencer

---
 rtl/op_sequencer.sv | 140 ++++++++++++++
 tb/tb_op_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/op_sequencer.sv
// op_sequencer: fetches instruction words from program memory and issues
// opcode/operand pairs to a control unit over a valid/ready handshake.
// Opcodes 0..9 are issued, 14 is HALT, everything else is a skipped NOP.
// Build option: define SEQ_HW_LOOP_EN to add single-level hardware loops
// (13 = LOOP count, 12 = ENDL); without it those opcodes are NOPs.
module op_sequencer #(
  parameter int unsigned OP_WIDTH  = 4,
  parameter int unsigned ARG_WIDTH = 12,
  parameter int unsigned PC_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [PC_WIDTH-1:0]           prog_addr,
  input  logic [OP_WIDTH+ARG_WIDTH-1:0] prog_data,
  output logic                          op_valid,
  input  logic                          op_ready,
  output logic [OP_WIDTH-1:0]           opcode,
  output logic [ARG_WIDTH-1:0]          operand
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_FINISH
  } state_t;

  localparam logic [OP_WIDTH-1:0] OPC_LAST_ISSUE = OP_WIDTH'(9);
  localparam logic [OP_WIDTH-1:0] OPC_HALT       = OP_WIDTH'(14);
`ifdef SEQ_HW_LOOP_EN
  localparam logic [OP_WIDTH-1:0] OPC_LOOP       = OP_WIDTH'(13);
  localparam logic [OP_WIDTH-1:0] OPC_ENDL       = OP_WIDTH'(12);
`endif

  state_t               state_q;
  logic [PC_WIDTH-1:0]  pc_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 op_valid_q;
  logic [OP_WIDTH-1:0]  opcode_q;
  logic [ARG_WIDTH-1:0] operand_q;
`ifdef SEQ_HW_LOOP_EN
  logic [ARG_WIDTH-1:0] loop_cnt_q;
  logic [PC_WIDTH-1:0]  loop_start_q;
`endif

  logic [OP_WIDTH-1:0]  dec_op_d;
  logic [ARG_WIDTH-1:0] dec_arg_d;
  logic [PC_WIDTH-1:0]  pc_inc_d;

  // Split the instruction word and form the sequential next address (wraps naturally).
  always_comb begin
    dec_op_d  = prog_data[OP_WIDTH+ARG_WIDTH-1 -: OP_WIDTH];
    dec_arg_d = prog_data[ARG_WIDTH-1:0];
    pc_inc_d  = pc_q + PC_WIDTH'(1);
  end

  // Sequencer FSM; all outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      op_valid_q   <= 1'b0;
      opcode_q     <= '0;
      operand_q    <= '0;
`ifdef SEQ_HW_LOOP_EN
      loop_cnt_q   <= '0;
      loop_start_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pc_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        // prog_addr follows pc_q; memory returns the word during DECODE.
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          if (dec_op_d <= OPC_LAST_ISSUE) begin
            opcode_q   <= dec_op_d;
            operand_q  <= dec_arg_d;
            op_valid_q <= 1'b1;
            state_q    <= S_ISSUE;
          end else if (dec_op_d == OPC_HALT) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_FINISH;
          end
`ifdef SEQ_HW_LOOP_EN
          else if (dec_op_d == OPC_LOOP) begin
            loop_cnt_q   <= dec_arg_d;
            loop_start_q <= pc_inc_d;
            pc_q         <= pc_inc_d;
            state_q      <= S_FETCH;
          end else if (dec_op_d == OPC_ENDL && loop_cnt_q != '0) begin
            loop_cnt_q <= loop_cnt_q - ARG_WIDTH'(1);
            pc_q       <= loop_start_q;
            state_q    <= S_FETCH;
          end
`endif
          else begin
            pc_q    <= pc_inc_d;
            state_q <= S_FETCH;
          end
        end
        S_ISSUE: begin
          if (op_ready) begin
            op_valid_q <= 1'b0;
            opcode_q   <= '0;
            operand_q  <= '0;
            pc_q       <= pc_inc_d;
            state_q    <= S_FETCH;
          end
        end
        S_FINISH: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign prog_addr = pc_q;
  assign op_valid  = op_valid_q;
  assign opcode    = opcode_q;
  assign operand   = operand_q;

endmodule

// File: tb/tb_op_sequencer.sv
// Self-checking bench for op_sequencer: directed scenarios plus random
// programs, compared against an instruction-level program interpreter.
module tb_op_sequencer;

  localparam int unsigned OPW    = 4;
  localparam int unsigned ARGW   = 12;
  localparam int unsigned PCW    = 8;
  localparam int unsigned BUDGET = 3000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              busy;
  logic              done;
  logic [PCW-1:0]    prog_addr;
  logic [15:0]       prog_data;
  logic              op_valid;
  logic              op_ready;
  logic [OPW-1:0]    opcode;
  logic [ARGW-1:0]   operand;

  logic [15:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_q[$];
  int          exp_total;
  int          hs_cnt;
  int          first_valid_k;
  int          hs_k[$];
`ifdef SEQ_HW_LOOP_EN
  int unsigned m_cnt   = 0;
  int unsigned m_start = 0;
`endif

  op_sequencer #(.OP_WIDTH(OPW), .ARG_WIDTH(ARGW), .PC_WIDTH(PCW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .prog_addr(prog_addr), .prog_data(prog_data), .op_valid(op_valid),
    .op_ready(op_ready), .opcode(opcode), .operand(operand)
  );

  always #5 clk = ~clk;

  // Synchronous-read program memory: word valid one cycle after the address.
  always @(posedge clk) prog_data <= mem[prog_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Interpret the program from address 0 and list the words that must be issued.
  task automatic model_run();
    int unsigned pc = 0;
    logic [15:0] w;
    exp_q.delete();
    for (int steps = 0; steps < 20000; steps++) begin
      w = mem[pc];
      if (w[15:12] <= 4'd9) begin
        exp_q.push_back(w);
        pc = (pc + 1) % 256;
      end else if (w[15:12] == 4'd14) begin
        break;
      end
`ifdef SEQ_HW_LOOP_EN
      else if (w[15:12] == 4'd13) begin
        m_cnt   = w[11:0];
        m_start = (pc + 1) % 256;
        pc      = m_start;
      end else if (w[15:12] == 4'd12 && m_cnt != 0) begin
        m_cnt = m_cnt - 1;
        pc    = m_start;
      end
`endif
      else begin
        pc = (pc + 1) % 256;
      end
    end
    exp_total = exp_q.size();
  endtask

  task automatic model_reset();
`ifdef SEQ_HW_LOOP_EN
    m_cnt   = 0;
    m_start = 0;
`endif
  endtask

  task automatic load_prog(input logic [15:0] p[$]);
    for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
    for (int i = 0; i < p.size(); i++) mem[i] = p[i];
  endtask

  // ready_mode: 0 = always ready, 1 = random, 2 = low for 5 cycles at first valid.
  task automatic run_prog(input int ready_mode, input bit poke_start);
    bit          finished = 0;
    bit          prev_stall = 0;
    logic [15:0] prev_w = '0;
    logic [15:0] w;
    int          dones = 0;
    int          stall_left = 5;
    model_run();
    hs_cnt = 0;
    first_valid_k = -1;
    hs_k.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= BUDGET && !finished; k++) begin
      if (k > 1) @(negedge clk);
      w = {opcode, operand};
      if (prev_stall) begin
        check("stall_valid", {31'b0, op_valid}, 32'd1);
        check("stall_word", {16'b0, w}, {16'b0, prev_w});
      end
      if (!op_valid) check("zero_when_idle", {16'b0, w}, 32'd0);
      else if (first_valid_k < 0) first_valid_k = k;
      if (done) begin
        dones++;
        check("busy_at_done", {31'b0, busy}, 32'd0);
        finished = 1;
      end else begin
        check("busy_running", {31'b0, busy}, 32'd1);
      end
      case (ready_mode)
        0: op_ready = 1'b1;
        1: op_ready = 1'($urandom_range(0, 1));
        default: begin
          if (op_valid && stall_left > 0) begin
            op_ready = 1'b0;
            stall_left--;
          end else begin
            op_ready = 1'b1;
          end
        end
      endcase
      start = poke_start && busy && ($urandom_range(0, 2) == 0);
      if (op_valid && op_ready) begin
        hs_cnt++;
        hs_k.push_back(k);
        if (exp_q.size() == 0) check("issue_excess", hs_cnt, exp_total);
        else check("issue_word", {16'b0, w}, {16'b0, exp_q.pop_front()});
      end
      prev_stall = op_valid && !op_ready;
      prev_w = w;
    end
    start = 1'b0;
    check("run_finished", {31'b0, finished}, 32'd1);
    check("issue_total", hs_cnt, exp_total);
    check("done_count", dones, 32'd1);
    @(negedge clk);
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("busy_after_done", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    logic [15:0] p[$];
    bit found;
    rst_n = 1'b0;
    start = 1'b0;
    op_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_valid", {31'b0, op_valid}, 32'd0);
    check("rst_word", {16'b0, opcode, operand}, 32'd0);
    check("rst_addr", {24'b0, prog_addr}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Two issued ops then HALT, ready tied high: latency 3, one op per 3 cycles.
    p = '{16'h0010, 16'h2020, 16'hE000};
    load_prog(p);
    run_prog(0, 0);
    check("basic_hs", hs_cnt, 32'd2);
    check("basic_first_valid", first_valid_k, 32'd3);
    if (hs_k.size() == 2) begin
      check("basic_hs0_cycle", hs_k[0], 32'd3);
      check("basic_hs1_cycle", hs_k[1], 32'd6);
    end else check("basic_hs_list", hs_k.size(), 32'd2);

    // Ready withheld for 5 cycles on the first ISSUE.
    run_prog(2, 0);
    check("stall_hs", hs_cnt, 32'd2);
    if (hs_k.size() >= 1) check("stall_hs0_cycle", hs_k[0], 32'd8);

    // Leading NOPs are skipped, never issued.
    p = '{16'hF000, 16'hF000, 16'h5003, 16'hE000};
    load_prog(p);
    run_prog(0, 0);
    check("nop_hs", hs_cnt, 32'd1);
    check("nop_first_valid", first_valid_k, 32'd7);

    // Opcodes 10/11 are NOPs in every build.
    p = '{16'hA123, 16'hB456, 16'h9FFF, 16'hE000};
    load_prog(p);
    run_prog(1, 1);
    check("resv_hs", hs_cnt, 32'd1);

    // Hardware loop: count 2 runs the body 3 times, count 0 once.
    p = '{16'hD002, 16'h0001, 16'hC000, 16'hE000};
    load_prog(p);
    run_prog(0, 0);
`ifdef SEQ_HW_LOOP_EN
    check("loop3_hs", hs_cnt, 32'd3);
`else
    check("noloop_hs", hs_cnt, 32'd1);
`endif
    p = '{16'hD000, 16'h0001, 16'hC000, 16'hE000};
    load_prog(p);
    run_prog(1, 0);
    check("loop0_hs", hs_cnt, 32'd1);

    // Reset during ISSUE drops op_valid and busy immediately.
    p = '{16'h0010, 16'h2020, 16'hE000};
    load_prog(p);
    op_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = op_valid;
    end
    check("rstmid_reach_issue", {31'b0, found}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_valid", {31'b0, op_valid}, 32'd0);
    check("rstmid_busy", {31'b0, busy}, 32'd0);
    check("rstmid_word", {16'b0, opcode, operand}, 32'd0);
    check("rstmid_addr", {24'b0, prog_addr}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rstmid_stays_idle", {31'b0, busy}, 32'd0);
    run_prog(0, 0);
    check("rstmid_rerun_hs", hs_cnt, 32'd2);

    // PC wraps from 255 to 0.
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    mem[255] = 16'h7ABC;
    op_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      found = op_valid;
    end
    check("wrap_reach", {31'b0, found}, 32'd1);
    check("wrap_word", {16'b0, opcode, operand}, 32'h7ABC);
    check("wrap_addr_before", {24'b0, prog_addr}, 32'd255);
    @(negedge clk);
    check("wrap_addr_after", {24'b0, prog_addr}, 32'd0);
    check("wrap_valid_drop", {31'b0, op_valid}, 32'd0);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random programs, random ready, spurious start pulses while busy.
    for (int r = 0; r < 24; r++) begin
      int len;
      logic [3:0] op;
      logic [11:0] arg;
      p.delete();
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        op  = 4'($urandom_range(0, 15));
        if (op == 4'd14) op = 4'd15;
        arg = 12'($urandom);
        if (op == 4'd13) arg = 12'($urandom_range(0, 3));
        p.push_back({op, arg});
      end
      load_prog(p);
      run_prog(r % 2, r % 3 == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
